// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences the core PLL and the core reset in the clk_74a domain. Pulses the
//   PLL reset, synchronizes the PLL lock indication, waits for lock to stay
//   stable before releasing the core reset, retries on lock timeout and
//   re-sequences on lock loss or on an explicit relock request.
//
// Ports
//   clk_74a       in   74.25 MHz reference clock (also the PLL refclk)
//   reset_n       in   async active-low reset, deassertion already synchronous
//   pll_locked    in   PLL locked, asynchronous to clk_74a
//   relock_req    in   single-cycle request to restart sequencing
//   pll_rst       out  PLL reset, active-high
//   core_reset_n  out  core reset, active-low
//   pll_ready     out  high while running
//   pll_fail      out  high once all retries are exhausted
//   lock_lost     out  one-cycle pulse when lock drops while running
//   retry_count   out  retries consumed in the current sequence
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  // Counter widths; a parameter of 1 still needs a one-bit counter.
  localparam int unsigned RST_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int unsigned STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int unsigned RTY_W = 4;

  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [RTY_W-1:0] retry_d;
  logic             lock_meta, lock_s;
  logic             timeout_c;
  logic             lock_lost_c;

  // Two-stage synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    to_cnt_d    = to_cnt_q;
    retry_d     = retry_count;
    lock_lost_c = 1'b0;
    timeout_c   = (to_cnt_q == TO_LAST);

    case (state_q)
      ST_RESET: begin
        // relock_req is deliberately ignored here so the pulse is never stretched.
        if (rst_cnt_q == RST_LAST) begin
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (relock_req) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end else if (timeout_c) begin
          if (retry_count < RETRY_MAX) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
            retry_d   = retry_count + RTY_W'(1);
          end else begin
            state_d = ST_FAIL;
          end
        end else if (lock_s) begin
          state_d   = ST_STABLE;
          stb_cnt_d = '0;
        end
      end

      ST_STABLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (relock_req) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end else if (lock_s && (stb_cnt_q == STB_LAST)) begin
          // Completion wins over a timeout landing on the same cycle.
          state_d = ST_RUN;
        end else if (timeout_c) begin
          if (retry_count < RETRY_MAX) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
            retry_d   = retry_count + RTY_W'(1);
          end else begin
            state_d = ST_FAIL;
          end
        end else if (!lock_s) begin
          // Drop back but keep the timeout running across the glitch.
          state_d = ST_WAIT_LOCK;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end

      ST_RUN: begin
        if (!lock_s) begin
          // Lock loss still pulses lock_lost when a relock arrives together.
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          retry_d     = '0;
          lock_lost_c = 1'b1;
        end else if (relock_req) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end
      end

      ST_FAIL: begin
        if (relock_req) begin
          state_d   = ST_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
        end
      end

      default: begin
        state_d   = ST_RESET;
        rst_cnt_d = '0;
        retry_d   = '0;
      end
    endcase
  end

  // State, counters and registered output decode.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      stb_cnt_q    <= '0;
      to_cnt_q     <= '0;
      retry_count  <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      pll_ready    <= 1'b0;
      pll_fail     <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_count  <= retry_d;
      pll_rst      <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      core_reset_n <= (state_d == ST_RUN);
      pll_ready    <= (state_d == ST_RUN);
      pll_fail     <= (state_d == ST_FAIL);
      lock_lost    <= lock_lost_c;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer. Stimulus pushes the expected output
// vector and the cycle at which it must appear; the monitor pops an entry on
// every observed change of the output vector and compares both.
module tb_pll_reset_sequencer;

  localparam int unsigned RST_PULSE = 4;
  localparam int unsigned STABLE    = 8;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned RETRIES   = 2;

  logic       clk_74a = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic       pll_fail;
  logic       lock_lost;
  logic [3:0] retry_count;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (RST_PULSE),
    .LOCK_STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES        (RETRIES)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .pll_ready   (pll_ready),
    .pll_fail    (pll_fail),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  always #5 clk_74a = ~clk_74a;

  // Rising edges seen so far.
  int cyc = 0;
  always @(posedge clk_74a) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // {pll_rst, core_reset_n, pll_ready, pll_fail, lock_lost, retry_count}
  function automatic logic [8:0] ov(input bit rst, input bit crn, input bit rdy,
                                    input bit fail, input bit lost, input int rc);
    return {rst, crn, rdy, fail, lost, 4'(rc)};
  endfunction

  function automatic logic [8:0] v_rst(input int rc);
    return ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rc);
  endfunction

  function automatic logic [8:0] v_wait(input int rc);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rc);
  endfunction

  function automatic logic [8:0] v_run();
    return ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
  endfunction

  function automatic logic [8:0] v_lost();
    return ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endfunction

  function automatic logic [8:0] v_fail(input int rc);
    return ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rc);
  endfunction

  task automatic exp_push(input int c, input logic [8:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = n;
    exp_q.push_back(e);
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  // Monitor: every change of the output vector must match the queue head.
  logic [8:0] mon_prev;
  bit         mon_seen = 1'b0;
  logic [8:0] mon_cur;
  exp_t       mon_e;

  always @(negedge clk_74a) begin
    mon_cur = {pll_rst, core_reset_n, pll_ready, pll_fail, lock_lost, retry_count};
    if (!mon_seen || (mon_cur != mon_prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc %0d got %h, nothing expected", cyc, mon_cur);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.cyc != cyc) || (mon_e.val != mon_cur)) begin
          errors++;
          $display("FAIL %s: got %h at cyc %0d, expected %h at cyc %0d",
                   mon_e.name, mon_cur, cyc, mon_e.val, mon_e.cyc);
        end
      end
    end
    mon_prev = mon_cur;
    mon_seen = 1'b1;
  end

  initial begin
    int c;
    int s;
    int r;
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #1 reset_n = 1'b0;
    // First monitor sample is the negedge after edge 1.
    exp_push(1, v_rst(0), "reset_values");

    // 1: nominal sequence
    step(3);
    reset_n = 1'b1;
    c = cyc;
    exp_push(c + 4, v_wait(0), "t1_pll_rst_4_edges");
    step(4 + 10);
    pll_locked = 1'b1;
    exp_push(cyc + 11, v_run(), "t1_core_release");
    step(15);

    // 4: lock loss in RUN, then resequence
    pll_locked = 1'b0;
    c = cyc;
    exp_push(c + 3, v_lost(), "t4_lock_lost_edge3");
    exp_push(c + 4, v_rst(0), "t4_lock_lost_single");
    exp_push(c + 7, v_wait(0), "t4_reseq_pulse");
    step(9);

    // 2: lock glitch during STABLE restarts the stable count
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    exp_push(cyc + 11, v_run(), "t2_glitch_release");
    step(15);

    // 6: lock loss and relock_req in the same RUN cycle
    pll_locked = 1'b0;
    step(2);
    relock_req = 1'b1;
    c = cyc;
    exp_push(c + 1, v_lost(), "t6_lost_with_relock");
    exp_push(c + 2, v_rst(0), "t6_lost_single");
    exp_push(c + 5, v_wait(0), "t6_single_reset");
    step(1);
    relock_req = 1'b0;
    step(6);
    pll_locked = 1'b1;
    exp_push(cyc + 11, v_run(), "t6_release");
    step(15);

    // 3: never lock, retries then FAIL, relock out of FAIL
    pll_locked = 1'b0;
    c = cyc;
    exp_push(c + 3,   v_lost(),  "t3_lost");
    exp_push(c + 4,   v_rst(0),  "t3_pulse1");
    exp_push(c + 7,   v_wait(0), "t3_wait1");
    exp_push(c + 71,  v_rst(1),  "t3_retry1");
    exp_push(c + 75,  v_wait(1), "t3_wait2");
    exp_push(c + 139, v_rst(2),  "t3_retry2");
    exp_push(c + 143, v_wait(2), "t3_wait3");
    exp_push(c + 207, v_fail(2), "t3_fail");
    step(215);
    relock_req = 1'b1;
    c = cyc;
    exp_push(c + 1, v_rst(0),  "t3_relock_from_fail");
    exp_push(c + 5, v_wait(0), "t3_relock_pulse");
    step(1);
    relock_req = 1'b0;

    // 5: async reset in STABLE with a retry already consumed
    step(4);
    exp_push(c + 69, v_rst(1),  "t5_retry1");
    exp_push(c + 73, v_wait(1), "t5_wait");
    step(70);
    pll_locked = 1'b1;
    s = cyc;
    step(5);
    #1;
    reset_n = 1'b0;
    exp_push(s + 5, v_rst(0), "t5_async_reset");
    step(2);
    reset_n = 1'b1;
    r = cyc;
    exp_push(r + 4,  v_wait(0), "t5_restart_pulse");
    exp_push(r + 13, v_run(),   "t5_restart_release");
    step(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected changes never seen, first %s at cyc %0d",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
